// File: rtl/button_pkg.sv
// button_pkg: shared types and timing defaults for board-input blocks.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HELD,
        DISARM
    } btn_state_e;

    localparam int PRESS_CNT_W     = 8;
    localparam int DEBOUNCE_100MHZ = 1_000_000;
    localparam int LONG_100MHZ     = 100_000_000;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser, async active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronised, edge-qualified button with press/release/long-press strobes.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ,
    parameter int LONG_CYCLES     = LONG_100MHZ,
    parameter int CNT_W           = 27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_i,
    output logic                   level_o,
    output logic                   press_o,
    output logic                   release_o,
    output logic                   long_press_o,
    output logic [PRESS_CNT_W-1:0] press_count_o
);

    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 1);

    btn_state_e       state_q;
    logic [CNT_W-1:0] stab_q;
    logic [CNT_W-1:0] hold_q;
    logic             btn_s;
    logic             holding;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_i),
        .q_o   (btn_s)
    );

    assign holding = (state_q == HELD) || (state_q == DISARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            stab_q        <= '0;
            hold_q        <= '0;
            level_o       <= 1'b0;
            press_o       <= 1'b0;
            release_o     <= 1'b0;
            long_press_o  <= 1'b0;
            press_count_o <= '0;
        end else begin
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            long_press_o <= holding && (hold_q == LONG_PRE);
            if (holding && (hold_q != LONG_MAX))
                hold_q <= hold_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q <= ARM;
                        stab_q  <= CNT_W'(1);
                    end
                end
                ARM: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                        stab_q  <= '0;
                    end else if (stab_q == STAB_MAX) begin
                        state_q       <= HELD;
                        press_o       <= 1'b1;
                        press_count_o <= press_count_o + 1'b1;
                        hold_q        <= '0;
                        level_o       <= 1'b1;
                    end else begin
                        stab_q <= stab_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_q <= DISARM;
                        stab_q  <= CNT_W'(1);
                    end
                end
                DISARM: begin
                    if (btn_s) begin
                        state_q <= HELD;
                    end else if (stab_q == STAB_MAX) begin
                        // an accepted release wins over a coincident long-press
                        state_q      <= IDLE;
                        stab_q       <= '0;
                        release_o    <= 1'b1;
                        long_press_o <= 1'b0;
                        level_o      <= 1'b0;
                    end else begin
                        stab_q <= stab_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench with directed button waveforms.
module tb_button_debounce;

    localparam int DB = 4;
    localparam int LG = 20;
    localparam int LAT = DB + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn = 1'b0;
    logic       level, press, rel, long_press;
    logic [7:0] press_count;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        logic [7:0] cnt;
        logic       lvl;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    button_debounce #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_i         (btn),
        .level_o       (level),
        .press_o       (press),
        .release_o     (rel),
        .long_press_o  (long_press),
        .press_count_o (press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(logic [2:0] kind, int c, logic lvl);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.cnt  = exp_cnt;
        e.lvl  = lvl;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kinds: 001 press, 010 release, 100 long_press
    task automatic pulse(int hi, int lo);
        int k;
        k = cyc;
        btn = 1'b1;
        exp_cnt++;
        push(3'b001, k + LAT, 1'b1);
        if (hi > LG) push(3'b100, k + LAT + LG, 1'b1);
        step(hi);
        btn = 1'b0;
        push(3'b010, k + hi + LAT, 1'b0);
        step(lo);
    endtask

    task automatic chk_zero_outs(string name);
        @(negedge clk);
        chk({name, "_level"}, 32'(level), 32'd0);
        chk({name, "_strobes"}, 32'({press, rel, long_press}), 32'd0);
        chk({name, "_count"}, 32'(press_count), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (press || rel || long_press)) begin
            ev_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got kind=%b cyc=%0d cnt=%0d, want none",
                         {long_press, rel, press}, cyc, press_count);
            end else begin
                e = q.pop_front();
                if ({long_press, rel, press} !== e.kind || cyc != e.cyc ||
                    press_count !== e.cnt || level !== e.lvl) begin
                    errors++;
                    $display("FAIL event: got kind=%b cyc=%0d cnt=%0d lvl=%b, want kind=%b cyc=%0d cnt=%0d lvl=%b",
                             {long_press, rel, press}, cyc, press_count, level,
                             e.kind, e.cyc, e.cnt, e.lvl);
                end
            end
        end
    end

    initial begin
        int k;
        logic [8:0] pat;
        #1 rst_n = 1'b0;
        step(2);
        chk_zero_outs("reset");
        step(0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);
        // clean press and release
        pulse(10, 12);
        chk("clean_level", 32'(level), 32'd0);
        chk("clean_count", 32'(press_count), 32'd1);
        // bounce rejection: never four consecutive highs
        pat = 9'b011101101;
        for (int i = 0; i < 9; i++) begin
            btn = pat[i];
            step(1);
        end
        btn = 1'b0;
        step(12);
        chk("bounce_level", 32'(level), 32'd0);
        chk("bounce_count", 32'(press_count), 32'd1);
        // release bounce: three-cycle drop while held, long-press still on time
        k = cyc;
        btn = 1'b1;
        exp_cnt++;
        push(3'b001, k + LAT, 1'b1);
        push(3'b100, k + LAT + LG, 1'b1);
        step(8);
        btn = 1'b0;
        step(3);
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rel_bounce_level", 32'(level), 32'd1);
            step(1);
        end
        btn = 1'b0;
        push(3'b010, k + 31 + LAT, 1'b0);
        step(12);
        chk("rel_bounce_count", 32'(press_count), 32'd2);
        // long press
        pulse(40, 12);
        chk("long_count", 32'(press_count), 32'd3);
        // counter wrap from a fresh reset
        rst_n = 1'b0;
        exp_cnt = 8'd0;
        step(1);
        rst_n = 1'b1;
        step(2);
        for (int i = 0; i < 257; i++) pulse(6, 8);
        chk("wrap_count", 32'(press_count), 32'd1);
        chk("wrap_level", 32'(level), 32'd0);
        // reset while held
        k = cyc;
        btn = 1'b1;
        exp_cnt++;
        push(3'b001, k + LAT, 1'b1);
        step(10);
        chk("held_level", 32'(level), 32'd1);
        #2 rst_n = 1'b0;
        exp_cnt = 8'd0;
        chk_zero_outs("mid_reset");
        step(1);
        rst_n = 1'b1;
        k = cyc;
        exp_cnt = 8'd1;
        push(3'b001, k + LAT, 1'b1);
        step(10);
        chk("post_reset_count", 32'(press_count), 32'd1);
        chk("post_reset_level", 32'(level), 32'd1);
        btn = 1'b0;
        push(3'b010, k + 10 + LAT, 1'b0);
        step(12);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
